// File: rtl/mux_demux_pkg.sv
// Shared definitions for the 4:1 mux serial link (transmit sequencer and receive demux).
package mux_demux_pkg;

    localparam int DEF_N_LANES = 4;
    localparam int DEF_SEL_W   = 2;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

endpackage

// File: rtl/demux4_1_seq_rx.sv
// Receive side of the 4:1 mux serial link: rebuilds one word from N_LANES (Y, sel) beats.
// Optional macro SEL_CHECK_EN enforces the descending sel order and flags violations on sel_err.
module demux4_1_seq_rx
    import mux_demux_pkg::*;
#(
    parameter int N_LANES = DEF_N_LANES,
    parameter int SEL_W   = DEF_SEL_W,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               Y_in,
    input  logic [SEL_W-1:0]   sel_in,
    output logic [N_LANES-1:0] X_out,
    output logic               out_valid,
    output logic               busy,
    output logic [CNT_W-1:0]   frame_cnt,
    output logic               sel_err
);

    localparam logic [SEL_W-1:0] SEL_TOP  = SEL_W'(N_LANES - 1);
    localparam logic [SEL_W-1:0] SEL_NEXT = SEL_W'(N_LANES - 2);

    state_t             state;
    logic [SEL_W-1:0]   exp_sel;
    logic [N_LANES-1:0] shadow;
    logic [N_LANES-1:0] merged;
    logic               start_ok;
    logic               seq_ok;

    // Shadow with the current beat folded in; used both for the write-back and the final word.
    always_comb begin
        merged         = shadow;
        merged[sel_in] = Y_in;
    end

`ifdef SEL_CHECK_EN
    assign start_ok = (sel_in == SEL_TOP);
    assign seq_ok   = (sel_in == exp_sel);
`else
    // Order is not policed: exp_sel only counts the beats still owed in this frame.
    assign start_ok = 1'b1;
    assign seq_ok   = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            exp_sel   <= SEL_TOP;
            shadow    <= '0;
            X_out     <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            frame_cnt <= '0;
            sel_err   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            sel_err   <= 1'b0;
            if (in_valid) begin
                case (state)
                    IDLE: begin
                        if (start_ok) begin
                            shadow  <= merged;
                            exp_sel <= SEL_NEXT;
                            state   <= COLLECT;
                            busy    <= 1'b1;
                        end
                    end
                    COLLECT: begin
                        if (!seq_ok) begin
                            // Drop the partial frame; the offending beat is not a new start.
                            sel_err <= 1'b1;
                            exp_sel <= SEL_TOP;
                            state   <= IDLE;
                            busy    <= 1'b0;
                        end else begin
                            shadow <= merged;
                            if (exp_sel == '0) begin
                                X_out     <= merged;
                                out_valid <= 1'b1;
                                frame_cnt <= frame_cnt + CNT_W'(1);
                                exp_sel   <= SEL_TOP;
                                state     <= IDLE;
                                busy      <= 1'b0;
                            end else begin
                                exp_sel <= exp_sel - SEL_W'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_demux4_1_seq_rx.sv
// Self-checking bench for demux4_1_seq_rx: frame-level reference model plus directed literal checks.
module tb_demux4_1_seq_rx;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       Y_in = 1'b0;
    logic [1:0] sel_in = 2'd0;
    logic [3:0] X_out;
    logic       out_valid;
    logic       busy;
    logic [7:0] frame_cnt;
    logic       sel_err;

    int checks = 0;
    int errors = 0;

    demux4_1_seq_rx #(.N_LANES(4), .SEL_W(2), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .Y_in(Y_in), .sel_in(sel_in),
        .X_out(X_out), .out_valid(out_valid), .busy(busy), .frame_cnt(frame_cnt),
        .sel_err(sel_err)
    );

    always #5 clk = ~clk;

    // Reference model: the frame in progress is a list of accepted lane indices.
    int   q_sel[$];
    bit   m_shadow[N];
    bit   [3:0] m_x = '0;
    bit   m_ov = 1'b0;
    bit   m_err = 1'b0;
    int   m_cnt = 0;

    task automatic m_reset();
        q_sel.delete();
        foreach (m_shadow[k]) m_shadow[k] = 1'b0;
        m_x = '0; m_ov = 1'b0; m_err = 1'b0; m_cnt = 0;
    endtask

    task automatic m_accept(input int s, input bit y);
        m_shadow[s] = y;
        q_sel.push_back(s);
        if (q_sel.size() == N) begin
            for (int k = 0; k < N; k++) m_x[k] = m_shadow[k];
            m_ov  = 1'b1;
            m_cnt = (m_cnt + 1) % 256;
            q_sel.delete();
        end
    endtask

    task automatic m_step(input bit v, input int s, input bit y);
        m_ov  = 1'b0;
        m_err = 1'b0;
        if (v) begin
`ifdef SEL_CHECK_EN
            if (q_sel.size() == 0) begin
                if (s == N - 1) m_accept(s, y);
            end else if (s != N - 1 - q_sel.size()) begin
                m_err = 1'b1;
                q_sel.delete();
            end else begin
                m_accept(s, y);
            end
`else
            m_accept(s, y);
`endif
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) m_reset();
        else m_step(in_valid, int'(sel_in), Y_in);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle: DUT outputs against the model.
    always @(negedge clk) begin
        chk("x_out",     32'(X_out),     32'(m_x));
        chk("out_valid", 32'(out_valid), 32'(m_ov));
        chk("busy",      32'(busy),      32'(q_sel.size() != 0));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
        chk("sel_err",   32'(sel_err),   32'(m_err));
    end

    task automatic beat(input int s, input bit y);
        in_valid = 1'b1;
        sel_in   = 2'(s);
        Y_in     = y;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        Y_in     = 1'($urandom);
        sel_in   = 2'($urandom);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [3:0] x);
        for (int s = N - 1; s >= 0; s--) beat(s, x[s]);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] x;
        int nxt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset_x", 32'(X_out), 32'h0);
        chk("reset_cnt", 32'(frame_cnt), 32'h0);
        idle(1);

        // Test 1: reset in the middle of a frame.
        beat(3, 1'b1);
        beat(2, 1'b1);
        chk("busy_mid", 32'(busy), 32'h1);
        in_valid = 1'b0;
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_x", 32'(X_out), 32'h0);
        chk("rst_ov", 32'(out_valid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        idle(1);

        // Test 2: single frame 4'b1010.
        send_frame(4'b1010);
        chk("t2_x", 32'(X_out), 32'hA);
        chk("t2_ov", 32'(out_valid), 32'h1);
        chk("t2_cnt", 32'(frame_cnt), 32'h1);
        idle(1);
        chk("t2_ov_pulse", 32'(out_valid), 32'h0);
        chk("t2_x_hold", 32'(X_out), 32'hA);

        // Test 3: back-to-back sweep 0..15.
        do_reset();
        for (int v = 0; v < 16; v++) begin
            send_frame(4'(v));
            chk("t3_x", 32'(X_out), 32'(v));
            chk("t3_ov", 32'(out_valid), 32'h1);
        end
        chk("t3_cnt", 32'(frame_cnt), 32'd16);
        idle(2);

        // Test 4: three idle cycles between beats.
        x = 4'h5;
        for (int s = N - 1; s >= 0; s--) begin
            beat(s, x[s]);
            if (s > 0) begin
                for (int g = 0; g < 3; g++) begin
                    idle(1);
                    chk("t4_busy", 32'(busy), 32'h1);
                end
            end
        end
        chk("t4_x", 32'(X_out), 32'h5);
        chk("t4_ov", 32'(out_valid), 32'h1);
        idle(1);

`ifdef SEL_CHECK_EN
        // Test 5: out-of-order sel aborts the frame.
        beat(3, 1'b0);
        beat(2, 1'b1);
        beat(0, 1'b1);
        chk("t5_err", 32'(sel_err), 32'h1);
        chk("t5_ov", 32'(out_valid), 32'h0);
        chk("t5_x", 32'(X_out), 32'h5);
        idle(1);
        chk("t5_err_pulse", 32'(sel_err), 32'h0);
        send_frame(4'hC);
        chk("t5_clean", 32'(X_out), 32'hC);
`else
        // Without checking, sel only addresses the shadow: ascending order still rebuilds the word.
        x = 4'h6;
        for (int s = 0; s < N; s++) beat(s, x[s]);
        chk("t5_asc", 32'(X_out), 32'h6);
        chk("t5_err0", 32'(sel_err), 32'h0);
`endif
        idle(1);

        // Randomised traffic, mostly well-ordered with occasional bad sel values.
        nxt = N - 1;
        for (int c = 0; c < 1500; c++) begin
            if (c == 700) begin
                do_reset();
                nxt = N - 1;
            end
            if ($urandom_range(0, 2) != 0) begin
                if ($urandom_range(0, 7) == 0) beat($urandom_range(0, N - 1), 1'($urandom));
                else beat(nxt, 1'($urandom));
                nxt = (nxt == 0) ? N - 1 : nxt - 1;
            end else begin
                idle(1);
            end
        end
        idle(2);

        // Test 6: frame counter wraps on the 256th completed frame.
        do_reset();
        for (int f = 0; f < 255; f++) send_frame(4'($urandom));
        chk("t6_cnt255", 32'(frame_cnt), 32'd255);
        send_frame(4'h9);
        chk("t6_wrap", 32'(frame_cnt), 32'd0);
        chk("t6_ov", 32'(out_valid), 32'h1);
        chk("t6_x", 32'(X_out), 32'h9);
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
